tx_intf_s_axis: RTL
===================

// Module: tx_intf_s_axis
// PURPOSE
// AXI-Stream slave taking TX sample/bit data from the DMA (MM2S) into a local FIFO
// for the TX accelerator to pull. Counterpart of the RX-side stream master: armed by
// a start pulse, waits a configurable delay, accepts NUM_DMA_SYMBOL+1 beats, checks
// TLAST framing and buffers data in a first-word-fall-through FIFO.
// PARAMETERS
// WAIT_COUNT_BITS         5     width of START_COUNT_CFG / arm delay counter
// MAX_NUM_DMA_SYMBOL      8192  max beats per transfer
// MAX_BIT_NUM_DMA_SYMBOL  14    width of symbol count / beat counter
// FIFO_ADDR_BITS          9     FIFO depth = 2**FIFO_ADDR_BITS entries
// C_S_AXIS_TDATA_WIDTH    64    stream / FIFO data width
// PORTS
// S_AXIS_ACLK            in   1      the only clock
// S_AXIS_RST             in   1      synchronous, active-high reset
// endless_mode           in   1      1: ignore count and TLAST, accept forever
// START_COUNT_CFG        in   WCB    arm delay; ARM lasts START_COUNT_CFG+1 cycles
// S_AXIS_NUM_DMA_SYMBOL  in   MBN    beats per transfer minus 1
// start_1trans           in   1      level; rising edge starts a transfer
// S_AXIS_TVALID          in   1      stream valid
// S_AXIS_TDATA           in   DW     stream data
// S_AXIS_TSTRB           in   DW/8   ignored (full beats only)
// S_AXIS_TLAST           in   1      stream last
// S_AXIS_TREADY          out  1      stream ready
// DATA_TO_ACC            out  DW     FIFO head word (valid when EMPTYN_TO_ACC=1)
// EMPTYN_TO_ACC          out  1      FIFO not empty
// ACC_ASK_DATA           in   1      pop FIFO head this cycle
// fifo_data_count        out  FAB+1  FIFO occupancy, 0..2**FIFO_ADDR_BITS
// beat_count             out  MBN    beats accepted in current transfer
// trans_done             out  1      level: transfer ended, held until next start
// err_tlast_early        out  1      sticky: TLAST before final beat
// err_tlast_missing      out  1      sticky: final beat without TLAST
// BEHAVIOUR
// - Reset: state IDLE; TREADY=0, EMPTYN=0, fifo_data_count=0, beat_count=0,
//   trans_done=0, both err=0; FIFO flushed; start edge register cleared.
// - start_pulse = start_1trans & ~start_1trans_d1 (d1 registered, reset 0).
// - start_pulse in ANY state: beat_count<=0, trans_done<=0, errs<=0, arm cnt<=0,
//   next state ARM. FIFO contents NOT flushed (only reset flushes).
// - FSM: IDLE -start_pulse-> ARM; ARM: cnt==START_COUNT_CFG -> RECV, cnt<=0, else cnt++;
//   RECV -> DONE on final/early-TLAST beat (never in endless_mode); DONE holds
//   (trans_done=1) until start_pulse.
// - TREADY = (state==RECV) & ~FULL & (endless_mode | beat_count<=NUM). Combinational
//   from registered state/FULL; never depends on TVALID. accept = TVALID & TREADY.
// - accept: FIFO write TDATA, beat_count++ (wraps mod 2**MBN in endless_mode).
// - Non-endless, accepted beat with beat_count==NUM: final beat -> DONE next cycle;
//   TLAST=0 here -> err_tlast_missing<=1.
// - Non-endless, accepted beat with TLAST=1 and beat_count<NUM: err_tlast_early<=1,
//   -> DONE; beat is still written to FIFO.
// - endless_mode: TLAST ignored, no errors, stays RECV until start_pulse/reset.
// - FIFO: FWFT; DATA_TO_ACC = head combinationally. pop = ACC_ASK_DATA & EMPTYN;
//   ACC_ASK_DATA while empty ignored. FULL = count==2**FAB. Push+pop same cycle:
//   count unchanged; allowed when nonempty. Pointers wrap mod depth. Write while
//   FULL impossible (TREADY=0); no bypass of empty FIFO (data visible cycle after push).
// - Reset mid-transfer: immediate return to reset values; in-flight beat not taken.
// TESTING
// - NUM=3, CFG=2, TVALID always, TLAST on beat 4: TREADY rises 3 cycles after ARM
//   entry, 4 beats accepted, trans_done=1, errs 0, fifo_data_count=4.
// - NUM=7, TLAST on beat 3: 3 beats accepted, err_tlast_early=1, TREADY=0 after,
//   trans_done=1; NUM=7 with no TLAST: 8 beats, err_tlast_missing=1.
// - FAB=2, NUM=9, no pops: TREADY drops at count 4; pop 1 -> exactly 1 more beat
//   accepted next cycle; draining all gives data in order 0..9.
// - endless_mode=1, 20 beats with random TLAST: all accepted, no done/err,
//   beat_count=20; concurrent push/pop keeps count constant.
// - Second start_pulse mid-RECV (beat_count=5): beat_count->0, state ARM, FIFO
//   data retained; S_AXIS_RST=1 mid-RECV: all outputs to reset values next cycle.

Source files
------------

// File: rtl/tx_intf_s_axis.sv
// AXI-Stream slave: DMA (MM2S) beats into a first-word-fall-through FIFO
// for the TX accelerator, with arm delay, beat counting and TLAST checks.
module tx_intf_s_axis #(
    parameter int WAIT_COUNT_BITS        = 5,
    parameter int MAX_NUM_DMA_SYMBOL     = 8192,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int FIFO_ADDR_BITS         = 9,
    parameter int C_S_AXIS_TDATA_WIDTH   = 64
) (
    input  logic                                S_AXIS_ACLK,
    input  logic                                S_AXIS_RST,
    input  logic                                endless_mode,
    input  logic [WAIT_COUNT_BITS-1:0]          START_COUNT_CFG,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   S_AXIS_NUM_DMA_SYMBOL,
    input  logic                                start_1trans,
    input  logic                                S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]     DATA_TO_ACC,
    output logic                                EMPTYN_TO_ACC,
    input  logic                                ACC_ASK_DATA,
    output logic [FIFO_ADDR_BITS:0]             fifo_data_count,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   beat_count,
    output logic                                trans_done,
    output logic                                err_tlast_early,
    output logic                                err_tlast_missing
);

    localparam int DEPTH = 2 ** FIFO_ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RECV, S_DONE} state_t;

    state_t                              r_state, w_state_nxt;
    logic                                r_start_d1;
    logic [WAIT_COUNT_BITS-1:0]          r_arm_cnt, w_arm_cnt_nxt;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   r_beat_cnt;
    logic                                r_err_early, r_err_missing;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]     r_mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0]           r_wptr, r_rptr;
    logic [FIFO_ADDR_BITS:0]             r_count;

    logic w_start_pulse, w_full, w_empty_n, w_ready;
    logic w_accept, w_pop, w_final, w_early, w_unused;

    // Strobes are ignored: only full beats are ever sent
    assign w_unused = ^S_AXIS_TSTRB ^ (MAX_NUM_DMA_SYMBOL == 0);

    assign w_start_pulse = start_1trans & ~r_start_d1;
    assign w_full        = (r_count == (FIFO_ADDR_BITS+1)'(DEPTH));
    assign w_empty_n     = (r_count != '0);
    assign w_ready       = (r_state == S_RECV) & ~w_full &
                           (endless_mode | (r_beat_cnt <= S_AXIS_NUM_DMA_SYMBOL));
    assign w_accept      = S_AXIS_TVALID & w_ready;
    assign w_pop         = ACC_ASK_DATA & w_empty_n;
    assign w_final       = w_accept & ~endless_mode &
                           (r_beat_cnt == S_AXIS_NUM_DMA_SYMBOL);
    assign w_early       = w_accept & ~endless_mode & S_AXIS_TLAST &
                           (r_beat_cnt < S_AXIS_NUM_DMA_SYMBOL);

    always_comb begin
        w_state_nxt   = r_state;
        w_arm_cnt_nxt = r_arm_cnt;
        if (w_start_pulse) begin
            w_state_nxt   = S_ARM;
            w_arm_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: w_state_nxt = S_IDLE;
                S_ARM: begin
                    if (r_arm_cnt == START_COUNT_CFG) begin
                        w_state_nxt   = S_RECV;
                        w_arm_cnt_nxt = '0;
                    end else begin
                        w_arm_cnt_nxt = r_arm_cnt + 1'b1;
                    end
                end
                S_RECV: if (w_final | w_early) w_state_nxt = S_DONE;
                S_DONE: w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_RST) begin
            r_state    <= S_IDLE;
            r_arm_cnt  <= '0;
            r_start_d1 <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_arm_cnt  <= w_arm_cnt_nxt;
            r_start_d1 <= start_1trans;
        end
    end

    // A new start wins over a beat landing in the same cycle
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_RST) begin
            r_beat_cnt    <= '0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else if (w_start_pulse) begin
            r_beat_cnt    <= '0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            if (w_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_final & ~S_AXIS_TLAST) r_err_missing <= 1'b1;
            if (w_early) r_err_early <= 1'b1;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + 1'b1;
            if (w_pop)    r_rptr <= r_rptr + 1'b1;
            unique case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (w_accept) r_mem[r_wptr] <= S_AXIS_TDATA;
    end

    assign S_AXIS_TREADY     = w_ready;
    assign DATA_TO_ACC       = r_mem[r_rptr];
    assign EMPTYN_TO_ACC     = w_empty_n;
    assign fifo_data_count   = r_count;
    assign beat_count        = r_beat_cnt;
    assign trans_done        = (r_state == S_DONE);
    assign err_tlast_early   = r_err_early;
    assign err_tlast_missing = r_err_missing;

endmodule
